ds18b20_sched: RTL and testbench
================================

DS18B20_SCHED -- requirements
Module: ds18b20_sched

Interface
REQ-001 The block SHALL expose these parameters (name, default, meaning), one per line:
- CONV_WAIT_CYC, 37_500_000, sys_clk cycles to wait after Convert T (750 ms at 50 MHz).
- POLL_CYC, 50_000_000, auto-poll period in sys_clk cycles (1 s).
- MAX_TRY, 3, presence attempts per transaction before error.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low; ports, one per line (name direction width meaning):
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  async active-low reset.
- start  in  1  one-cycle host measurement request.
- auto_en  in  1  enable periodic polling.
- ow_ready  in  1  1-wire bit engine idle, can accept a command.
- ow_done  in  1  one-cycle pulse, engine finished the current command.
- ow_presence  in  1  presence result, valid with ow_done of a RESET command.
- ow_rdata  in  8  byte read, LSB first on the wire, valid with ow_done of a READ command.
- ow_req  out  1  one-cycle command strobe to engine.
- ow_cmd  out  2  00 RESET, 01 WRITE byte, 10 READ byte.
- ow_wdata  out  8  byte to write, held stable from ow_req to ow_done.
- temp_raw  out  16  last scratchpad bytes {MSB,LSB}, two's complement, 1/16 degC.
- temp_valid  out  1  one-cycle pulse when temp_raw updates.
- busy  out  1  high from transaction launch to return to IDLE.
- err_nopres  out  1  sticky no-presence error flag.

Function
REQ-003 The FSM SHALL use states IDLE, RST1, SKIP1, CONV, WAIT_CONV, RST2, SKIP2, RDSCR, RD_LSB, RD_MSB, DONE.
REQ-004 Each command state SHALL assert ow_req for exactly one cycle on the first cycle it is in the state with ow_ready=1, then hold until ow_done; it SHALL advance on the cycle after ow_done.
REQ-005 Command sequence: RST1 RESET; SKIP1 WRITE 8'hCC; CONV WRITE 8'h44; RST2 RESET; SKIP2 WRITE 8'hCC; RDSCR WRITE 8'hBE; RD_LSB READ; RD_MSB READ.
REQ-006 WAIT_CONV SHALL issue no command and SHALL last exactly CONV_WAIT_CYC cycles before entering RST2.
REQ-007 RD_LSB SHALL capture ow_rdata into a LSB holding register; in RD_MSB, temp_raw SHALL update to {ow_rdata, LSB} on the ow_done cycle, with temp_valid pulsing on the following cycle in DONE.
REQ-008 DONE SHALL last one cycle, clear err_nopres, and return to IDLE.
REQ-009 If ow_done in RST1/RST2 arrives with ow_presence=0, the try counter SHALL increment and the FSM SHALL restart at RST1. When MAX_TRY attempts have failed, it SHALL set err_nopres and return to IDLE without updating temp_raw or pulsing temp_valid.
REQ-010 The try counter SHALL clear on each launch from IDLE.
REQ-011 The poll timer SHALL count 0..POLL_CYC-1 while auto_en=1, generating a tick at wrap; it SHALL be held at 0 while auto_en=0.
REQ-012 A start or a tick SHALL set a single pending bit, which SHALL be cleared by the launch; further requests while pending or busy SHALL merge into that one bit (no queueing beyond one).
REQ-013 IDLE SHALL launch into RST1 on the cycle after pending=1; busy SHALL be high in every non-IDLE state.
REQ-014 ow_done received in a state not awaiting it SHALL be ignored.

Reset
REQ-015 Asserting sys_rst_n=0 SHALL force: state IDLE, all counters 0, pending 0, ow_req 0, ow_cmd 00, ow_wdata 8'h00, temp_raw 16'h0000, temp_valid 0, busy 0, err_nopres 0.
REQ-016 Reset mid-transaction SHALL abandon the transaction immediately; after release the block SHALL issue no command until a new start or tick.

Structure
REQ-017 A shared package SHALL hold the ow_cmd encodings, the DS18B20 opcodes (CC, 44, BE), and the state encoding.
REQ-018 The poll timer SHALL be a sub-module, ds18b20_poll_timer (auto_en in, tick out).
REQ-019 The bit-level 1-wire timing engine SHALL be external; this block SHALL contain no 1-wire timing.

Verification (CONV_WAIT_CYC=100, POLL_CYC=500, engine BFM answering 10 cycles after ow_req)
REQ-020 start pulse, presence=1, bytes 8'h91 then 8'h01 -> command order RESET,CC,44,(100-cycle gap),RESET,CC,BE,READ,READ; temp_raw=16'h0191; one temp_valid pulse.
REQ-021 presence=0 on every RESET -> exactly 3 RESETs, err_nopres=1, no temp_valid; a later good transaction clears err_nopres.
REQ-022 presence=0 on the first RESET only -> 2 RESETs before CC, transaction completes normally.
REQ-023 auto_en=1 held for 1600 cycles with no start -> 3 transactions launched at ticks; start during busy -> exactly one extra transaction.
REQ-024 sys_rst_n pulsed low during WAIT_CONV -> outputs at reset values, no ow_req until next start.
REQ-025 bytes 8'h5E then 8'hFF -> temp_raw=16'hFF5E (-10.125 degC).

Source files
------------

// File: rtl/ds18b20_sched_pkg.sv
// Shared definitions for the DS18B20 transaction scheduler: engine command
// codes, ROM/function opcodes, FSM state encoding and the per-state command.
package ds18b20_sched_pkg;

    localparam logic [1:0] OW_CMD_RESET = 2'b00;
    localparam logic [1:0] OW_CMD_WRITE = 2'b01;
    localparam logic [1:0] OW_CMD_READ  = 2'b10;

    localparam logic [7:0] DS_SKIP_ROM  = 8'hCC;
    localparam logic [7:0] DS_CONVERT_T = 8'h44;
    localparam logic [7:0] DS_READ_SCR  = 8'hBE;

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        RST1      = 4'd1,
        SKIP1     = 4'd2,
        CONV      = 4'd3,
        WAIT_CONV = 4'd4,
        RST2      = 4'd5,
        SKIP2     = 4'd6,
        RDSCR     = 4'd7,
        RD_LSB    = 4'd8,
        RD_MSB    = 4'd9,
        DONE      = 4'd10
    } state_t;

    typedef struct packed {
        logic [1:0] cmd;
        logic [7:0] wdata;
    } ow_op_t;

    function automatic logic is_cmd_state(state_t s);
        return !(s == IDLE || s == WAIT_CONV || s == DONE);
    endfunction

    // Command and payload presented to the engine while sitting in a state;
    // non-command states present RESET/00 so the bus stays at its idle value.
    function automatic ow_op_t state_op(state_t s);
        ow_op_t op;
        op.cmd   = OW_CMD_RESET;
        op.wdata = 8'h00;
        case (s)
            SKIP1, SKIP2: begin
                op.cmd   = OW_CMD_WRITE;
                op.wdata = DS_SKIP_ROM;
            end
            CONV: begin
                op.cmd   = OW_CMD_WRITE;
                op.wdata = DS_CONVERT_T;
            end
            RDSCR: begin
                op.cmd   = OW_CMD_WRITE;
                op.wdata = DS_READ_SCR;
            end
            RD_LSB, RD_MSB: op.cmd = OW_CMD_READ;
            default: ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ds18b20_poll_timer.sv
// Free-running poll period counter; emits a one-cycle tick at each wrap and
// sits at zero whenever polling is disabled.
module ds18b20_poll_timer #(
    parameter int POLL_CYC = 50_000_000
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic auto_en,
    output logic tick
);

    localparam int CNT_W = $clog2(POLL_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_CYC - 1);

    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        tick     = auto_en && (cnt_reg == CNT_LAST);
        cnt_next = cnt_reg + 1'b1;
        if (!auto_en || tick) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/ds18b20_sched.sv
// DS18B20 measurement scheduler: sequences reset/skip/convert/read-scratchpad
// commands to an external 1-wire bit engine and publishes the raw temperature.
module ds18b20_sched
    import ds18b20_sched_pkg::*;
#(
    parameter int CONV_WAIT_CYC = 37_500_000,
    parameter int POLL_CYC      = 50_000_000,
    parameter int MAX_TRY       = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic        auto_en,
    input  logic        ow_ready,
    input  logic        ow_done,
    input  logic        ow_presence,
    input  logic [7:0]  ow_rdata,
    output logic        ow_req,
    output logic [1:0]  ow_cmd,
    output logic [7:0]  ow_wdata,
    output logic [15:0] temp_raw,
    output logic        temp_valid,
    output logic        busy,
    output logic        err_nopres
);

    localparam int WAIT_W = $clog2(CONV_WAIT_CYC + 1);
    localparam int TRY_W  = $clog2(MAX_TRY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CONV_WAIT_CYC - 1);

    state_t              state_reg, state_next;
    logic                issued_reg, issued_next;
    logic [TRY_W-1:0]    try_reg, try_next;
    logic [WAIT_W-1:0]   wait_reg, wait_next;
    logic [7:0]          lsb_reg, lsb_next;
    logic [15:0]         temp_raw_reg, temp_raw_next;
    logic                err_reg, err_next;
    logic                pending_reg, pending_next;
    logic                tick;
    logic                launch;
    logic                got_done;
    ow_op_t              op;

    ds18b20_poll_timer #(
        .POLL_CYC (POLL_CYC)
    ) u_poll_timer (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .auto_en   (auto_en),
        .tick      (tick)
    );

    always_comb begin
        state_next    = state_reg;
        issued_next   = issued_reg;
        try_next      = try_reg;
        wait_next     = wait_reg;
        lsb_next      = lsb_reg;
        temp_raw_next = temp_raw_reg;
        err_next      = err_reg;
        launch        = 1'b0;
        op            = state_op(state_reg);
        // issued_reg gates ow_done so stray completions are ignored
        ow_req        = is_cmd_state(state_reg) && !issued_reg && ow_ready;
        got_done      = issued_reg && ow_done;

        if (ow_req) begin
            issued_next = 1'b1;
        end
        if (got_done) begin
            issued_next = 1'b0;
        end

        case (state_reg)
            IDLE: begin
                if (pending_reg) begin
                    launch     = 1'b1;
                    try_next   = '0;
                    state_next = RST1;
                end
            end
            RST1, RST2: begin
                if (got_done) begin
                    if (ow_presence) begin
                        state_next = (state_reg == RST1) ? SKIP1 : SKIP2;
                    end else if (int'(try_reg) + 1 >= MAX_TRY) begin
                        err_next   = 1'b1;
                        state_next = IDLE;
                    end else begin
                        try_next   = try_reg + 1'b1;
                        state_next = RST1;
                    end
                end
            end
            SKIP1:  if (got_done) state_next = CONV;
            CONV:   if (got_done) state_next = WAIT_CONV;
            WAIT_CONV: begin
                if (wait_reg == WAIT_LAST) begin
                    wait_next  = '0;
                    state_next = RST2;
                end else begin
                    wait_next  = wait_reg + 1'b1;
                end
            end
            SKIP2:  if (got_done) state_next = RDSCR;
            RDSCR:  if (got_done) state_next = RD_LSB;
            RD_LSB: begin
                if (got_done) begin
                    lsb_next   = ow_rdata;
                    state_next = RD_MSB;
                end
            end
            RD_MSB: begin
                if (got_done) begin
                    temp_raw_next = {ow_rdata, lsb_reg};
                    state_next    = DONE;
                end
            end
            DONE: begin
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        // Requests arriving while one is already pending or running collapse into one
        pending_next = launch ? 1'b0 : (pending_reg | start | tick);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_reg    <= IDLE;
            issued_reg   <= 1'b0;
            try_reg      <= '0;
            wait_reg     <= '0;
            lsb_reg      <= 8'h00;
            temp_raw_reg <= 16'h0000;
            err_reg      <= 1'b0;
            pending_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            issued_reg   <= issued_next;
            try_reg      <= try_next;
            wait_reg     <= wait_next;
            lsb_reg      <= lsb_next;
            temp_raw_reg <= temp_raw_next;
            err_reg      <= err_next;
            pending_reg  <= pending_next;
        end
    end

    assign ow_cmd     = op.cmd;
    assign ow_wdata   = op.wdata;
    assign temp_raw   = temp_raw_reg;
    assign temp_valid = (state_reg == DONE);
    assign busy       = (state_reg != IDLE);
    assign err_nopres = err_reg;

endmodule

// File: tb/tb_ds18b20_sched.sv
// Directed bench for ds18b20_sched with a simple 1-wire engine model that
// completes each command 10 cycles after its request.
module tb_ds18b20_sched;
    import ds18b20_sched_pkg::*;

    localparam int CONV_WAIT = 100;
    localparam int POLL      = 500;
    localparam int LOG_MAX   = 512;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n;
    logic        start;
    logic        auto_en;
    logic        ow_ready = 1'b1;
    logic        ow_done = 1'b0;
    logic        ow_presence = 1'b0;
    logic [7:0]  ow_rdata = 8'h00;
    logic        ow_req;
    logic [1:0]  ow_cmd;
    logic [7:0]  ow_wdata;
    logic [15:0] temp_raw;
    logic        temp_valid;
    logic        busy;
    logic        err_nopres;

    ds18b20_sched #(
        .CONV_WAIT_CYC (CONV_WAIT),
        .POLL_CYC      (POLL),
        .MAX_TRY       (3)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .start       (start),
        .auto_en     (auto_en),
        .ow_ready    (ow_ready),
        .ow_done     (ow_done),
        .ow_presence (ow_presence),
        .ow_rdata    (ow_rdata),
        .ow_req      (ow_req),
        .ow_cmd      (ow_cmd),
        .ow_wdata    (ow_wdata),
        .temp_raw    (temp_raw),
        .temp_valid  (temp_valid),
        .busy        (busy),
        .err_nopres  (err_nopres)
    );

    always #10 sys_clk = ~sys_clk;

    // test-owned engine configuration
    logic [7:0] rd_lo = 8'h00;
    logic [7:0] rd_hi = 8'h00;
    int         fail_n = 0;
    int         fail_mark = 0;

    // engine model / command log state
    logic [1:0] log_cmd [LOG_MAX];
    logic [7:0] log_wd  [LOG_MAX];
    int         log_cyc [LOG_MAX];
    int         log_n = 0;
    int         cyc = 0;
    int         rst_total = 0;
    int         bfm_cnt = 0;
    logic       bfm_pres = 1'b0;
    logic [7:0] bfm_data = 8'h00;
    logic       rd_sel = 1'b0;
    int         tv_cnt = 0;
    int         tx_cnt = 0;
    logic       busy_d = 1'b0;

    always @(posedge sys_clk) begin
        cyc    <= cyc + 1;
        busy_d <= busy;
        if (temp_valid) tv_cnt <= tv_cnt + 1;
        if (busy && !busy_d) tx_cnt <= tx_cnt + 1;
        if (!sys_rst_n) begin
            ow_ready <= 1'b1;
            ow_done  <= 1'b0;
            bfm_cnt  <= 0;
        end else begin
            ow_done <= 1'b0;
            if (ow_req && bfm_cnt == 0) begin
                if (log_n < LOG_MAX) begin
                    log_cmd[log_n] <= ow_cmd;
                    log_wd[log_n]  <= ow_wdata;
                    log_cyc[log_n] <= cyc;
                end
                log_n    <= log_n + 1;
                ow_ready <= 1'b0;
                bfm_cnt  <= 10;
                if (ow_cmd == OW_CMD_RESET) begin
                    bfm_pres  <= ((rst_total - fail_mark) >= fail_n);
                    rst_total <= rst_total + 1;
                    rd_sel    <= 1'b0;
                end else if (ow_cmd == OW_CMD_READ) begin
                    bfm_data <= rd_sel ? rd_hi : rd_lo;
                    rd_sel   <= ~rd_sel;
                end
            end else if (bfm_cnt != 0) begin
                if (bfm_cnt == 1) begin
                    ow_done     <= 1'b1;
                    ow_ready    <= 1'b1;
                    ow_presence <= bfm_pres;
                    ow_rdata    <= bfm_data;
                end
                bfm_cnt <= bfm_cnt - 1;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic pulse_start();
        @(negedge sys_clk);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 3000) begin
            @(negedge sys_clk);
            k++;
        end
        if (k >= 3000) chk("idle_timeout", 32'd1, 32'd0);
    endtask

    task automatic run_txn(input string name, input logic [7:0] lo, input logic [7:0] hi,
                           input int fails, output int n0, output int tv0);
        rd_lo     = lo;
        rd_hi     = hi;
        fail_n    = fails;
        fail_mark = rst_total;
        n0        = log_n;
        tv0       = tv_cnt;
        pulse_start();
        wait_cyc(3);
        wait_idle();
        wait_cyc(2);
        $display("txn %s: cmds=%0d temp_raw=%h temp_valid_pulses=%0d err_nopres=%0b",
                 name, log_n - n0, temp_raw, tv_cnt - tv0, err_nopres);
    endtask

    logic [1:0] exp_cmd [8];
    logic [7:0] exp_wd  [8];
    int n0, tv0, tx0, lg0;

    initial begin
        exp_cmd = '{OW_CMD_RESET, OW_CMD_WRITE, OW_CMD_WRITE, OW_CMD_RESET,
                    OW_CMD_WRITE, OW_CMD_WRITE, OW_CMD_READ, OW_CMD_READ};
        exp_wd  = '{8'h00, 8'hCC, 8'h44, 8'h00, 8'hCC, 8'hBE, 8'h00, 8'h00};
        sys_rst_n = 1'b0;
        start     = 1'b0;
        auto_en   = 1'b0;
        wait_cyc(3);
        chk("rst_temp_raw",   32'(temp_raw),   32'h0);
        chk("rst_temp_valid", 32'(temp_valid), 32'h0);
        chk("rst_busy",       32'(busy),       32'h0);
        chk("rst_err",        32'(err_nopres), 32'h0);
        chk("rst_ow_req",     32'(ow_req),     32'h0);
        chk("rst_ow_cmd",     32'(ow_cmd),     32'h0);
        chk("rst_ow_wdata",   32'(ow_wdata),   32'h0);
        sys_rst_n = 1'b1;
        wait_cyc(5);
        chk("no_cmd_after_rst", 32'(log_n), 32'd0);

        // nominal transaction
        run_txn("nominal", 8'h91, 8'h01, 0, n0, tv0);
        chk("nom_cmd_count", 32'(log_n - n0), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("nom_cmd%0d", i), 32'(log_cmd[n0+i]), 32'(exp_cmd[i]));
            if (exp_cmd[i] == OW_CMD_WRITE)
                chk($sformatf("nom_wd%0d", i), 32'(log_wd[n0+i]), 32'(exp_wd[i]));
        end
        chk("nom_wait_gap", 32'((log_cyc[n0+3] - log_cyc[n0+2]) - (log_cyc[n0+2] - log_cyc[n0+1])),
            32'd100);
        chk("nom_temp_raw", 32'(temp_raw), 32'h0191);
        chk("nom_tv_pulses", 32'(tv_cnt - tv0), 32'd1);
        chk("nom_err", 32'(err_nopres), 32'h0);

        // negative temperature
        run_txn("negative", 8'h5E, 8'hFF, 0, n0, tv0);
        chk("neg_temp_raw", 32'(temp_raw), 32'hFF5E);
        chk("neg_tv_pulses", 32'(tv_cnt - tv0), 32'd1);

        // no device answering
        run_txn("no_presence", 8'h12, 8'h34, 99, n0, tv0);
        chk("np_cmd_count", 32'(log_n - n0), 32'd3);
        for (int i = 0; i < 3; i++)
            chk($sformatf("np_cmd%0d", i), 32'(log_cmd[n0+i]), 32'(OW_CMD_RESET));
        chk("np_err", 32'(err_nopres), 32'h1);
        chk("np_tv_pulses", 32'(tv_cnt - tv0), 32'd0);
        chk("np_temp_kept", 32'(temp_raw), 32'hFF5E);

        run_txn("recover", 8'h50, 8'h00, 0, n0, tv0);
        chk("rec_err_cleared", 32'(err_nopres), 32'h0);
        chk("rec_temp_raw", 32'(temp_raw), 32'h0050);

        // first presence missing only
        run_txn("retry_once", 8'h20, 8'h01, 1, n0, tv0);
        chk("r1_cmd_count", 32'(log_n - n0), 32'd9);
        chk("r1_cmd0", 32'(log_cmd[n0]),   32'(OW_CMD_RESET));
        chk("r1_cmd1", 32'(log_cmd[n0+1]), 32'(OW_CMD_RESET));
        chk("r1_cmd2", 32'(log_cmd[n0+2]), 32'(OW_CMD_WRITE));
        chk("r1_wd2",  32'(log_wd[n0+2]),  32'hCC);
        chk("r1_temp_raw", 32'(temp_raw), 32'h0120);
        chk("r1_tv_pulses", 32'(tv_cnt - tv0), 32'd1);

        // reset during conversion wait
        rd_lo = 8'h77; rd_hi = 8'h07; fail_n = 0; fail_mark = rst_total;
        n0 = log_n; tv0 = tv_cnt;
        pulse_start();
        begin
            int k;
            k = 0;
            while (log_n < n0 + 3 && k < 500) begin
                @(negedge sys_clk);
                k++;
            end
            if (k >= 500) chk("conv_timeout", 32'd1, 32'd0);
        end
        wait_cyc(30);
        chk("pre_rst_busy", 32'(busy), 32'h1);
        sys_rst_n = 1'b0;
        wait_cyc(2);
        chk("mid_rst_busy",     32'(busy),     32'h0);
        chk("mid_rst_temp_raw", 32'(temp_raw), 32'h0);
        chk("mid_rst_ow_req",   32'(ow_req),   32'h0);
        sys_rst_n = 1'b1;
        lg0 = log_n;
        wait_cyc(300);
        chk("post_rst_no_cmd", 32'(log_n - lg0), 32'd0);
        chk("post_rst_no_tv",  32'(tv_cnt - tv0), 32'd0);
        chk("post_rst_busy",   32'(busy), 32'h0);
        $display("txn reset_in_wait: cmds_before_reset=%0d cmds_after=%0d temp_raw=%h",
                 lg0 - n0, log_n - lg0, temp_raw);

        // auto polling
        rd_lo = 8'h10; rd_hi = 8'h02; fail_n = 0; fail_mark = rst_total;
        tx0 = tx_cnt; tv0 = tv_cnt;
        @(negedge sys_clk);
        auto_en = 1'b1;
        wait_cyc(1600);
        auto_en = 1'b0;
        wait_cyc(400);
        chk("poll_tx_count", 32'(tx_cnt - tx0), 32'd3);
        chk("poll_tv_count", 32'(tv_cnt - tv0), 32'd3);
        chk("poll_temp_raw", 32'(temp_raw), 32'h0210);
        $display("txn auto_poll: transactions=%0d temp_raw=%h", tx_cnt - tx0, temp_raw);

        // starts during busy merge into one extra transaction
        tx0 = tx_cnt;
        pulse_start();
        wait_cyc(20);
        pulse_start();
        wait_cyc(20);
        pulse_start();
        wait_cyc(1000);
        chk("merge_tx_count", 32'(tx_cnt - tx0), 32'd2);
        chk("merge_idle", 32'(busy), 32'h0);
        $display("txn merged_starts: transactions=%0d", tx_cnt - tx0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
